// File: rtl/serial_clock.sv
// Integer clock divider producing a serial clock and aligned one-cycle edge strobes.
// The counter runs only while enabled. The idle level and the first edge are set by CPOL.
module serial_clock #(
  parameter int unsigned HALF_PERIOD = 2,
  parameter logic        CPOL        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic sclkPosEdge,
  output logic sclkNegEdge
);

  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             pos_q, pos_d;
  logic             neg_q, neg_d;

  // Next-state: toggle at the end of each half-period; strobe marks the new level
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    pos_d  = 1'b0;
    neg_d  = 1'b0;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = CPOL;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
      pos_d  = ~sclk_q;
      neg_d  = sclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= CPOL;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
    end
  end

  assign sclk        = sclk_q;
  assign sclkPosEdge = pos_q;
  assign sclkNegEdge = neg_q;

endmodule

// File: tb/tb_serial_clock.sv
// Bench for serial_clock. Three parameterisations run side by side.
// Each one is compared against an arithmetic model of enabled-cycle count.
`timescale 1ns/1ps
module tb_serial_clock;

  logic clk = 1'b0;
  logic rst_n;
  logic en_a, en_b, en_c;
  logic sclk_a, pos_a, neg_a;
  logic sclk_b, pos_b, neg_b;
  logic sclk_c, pos_c, neg_c;

  int vectors = 0;
  int errors  = 0;

  always #10 clk = ~clk;

  serial_clock #(.HALF_PERIOD(2), .CPOL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a),
    .sclk(sclk_a), .sclkPosEdge(pos_a), .sclkNegEdge(neg_a));
  serial_clock #(.HALF_PERIOD(1), .CPOL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b),
    .sclk(sclk_b), .sclkPosEdge(pos_b), .sclkNegEdge(neg_b));
  serial_clock #(.HALF_PERIOD(3), .CPOL(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_c),
    .sclk(sclk_c), .sclkPosEdge(pos_c), .sclkNegEdge(neg_c));

  // Reference model: number of consecutive enabled posedges since idle/reset
  int ka, kb, kc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ka <= 0; kb <= 0; kc <= 0;
    end else begin
      ka <= en_a ? ka + 1 : 0;
      kb <= en_b ? kb + 1 : 0;
      kc <= en_c ? kc + 1 : 0;
    end
  end

  function automatic logic exp_sclk(int k, int hp, logic cpol);
    return cpol ^ logic'((k / hp) % 2);
  endfunction
  function automatic logic exp_pos(int k, int hp, logic cpol);
    return (k > 0) && (k % hp == 0) && (exp_sclk(k, hp, cpol) == 1'b1);
  endfunction
  function automatic logic exp_neg(int k, int hp, logic cpol);
    return (k > 0) && (k % hp == 0) && (exp_sclk(k, hp, cpol) == 1'b0);
  endfunction

  // Strobe-driven consumer flop
  logic cons_d, cons_q;
  initial begin
    cons_d = 1'b1;
    #500 cons_d = 1'b0;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cons_q <= 1'b0;
    else if (neg_a) cons_q <= cons_d;
  end

  task automatic test_reset();
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({sclk_a, pos_a, neg_a} !== 3'b000) begin
      errors++; $display("FAIL reset_a got %b want 000", {sclk_a, pos_a, neg_a});
    end
    vectors++;
    if ({sclk_b, pos_b, neg_b} !== 3'b000) begin
      errors++; $display("FAIL reset_b got %b want 000", {sclk_b, pos_b, neg_b});
    end
    vectors++;
    if ({sclk_c, pos_c, neg_c} !== 3'b100) begin
      errors++; $display("FAIL reset_c got %b want 100", {sclk_c, pos_c, neg_c});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_consumer();
    logic pending = 1'b0;
    logic pend_val = 1'b0;
    int seen1 = 0, seen0 = 0;
    en_a = 1'b1;
    while ($time < 900) begin
      @(negedge clk); #1;
      if (pending) begin
        vectors++;
        if (cons_q !== pend_val) begin
          errors++; $display("FAIL consumer_q t=%0t got %b want %b", $time, cons_q, pend_val);
        end
        if (pend_val) seen1++; else seen0++;
      end
      pending  = neg_a;
      pend_val = cons_d;
    end
    vectors++;
    if (seen1 == 0 || seen0 == 0) begin
      errors++; $display("FAIL consumer_cover got ones=%0d zeros=%0d want both >0", seen1, seen0);
    end
    en_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_sequence();
    en_a = 1'b0; @(negedge clk);
    en_a = 1'b1;
    for (int p = 1; p <= 12; p++) begin
      @(negedge clk);
      vectors++;
      if ({sclk_a, pos_a, neg_a} !== {logic'((p / 2) % 2), logic'(p % 4 == 2), logic'(p % 4 == 0)}) begin
        errors++;
        $display("FAIL basic_seq p=%0d got %b want %b", p, {sclk_a, pos_a, neg_a},
                 {logic'((p / 2) % 2), logic'(p % 4 == 2), logic'(p % 4 == 0)});
      end
    end
    en_a = 1'b0; @(negedge clk);
  endtask

  task automatic test_count_100();
    int np = 0, nn = 0, nov = 0;
    en_a = 1'b1;
    repeat (100) begin
      @(negedge clk);
      np += int'(pos_a); nn += int'(neg_a);
      if (pos_a && neg_a) nov++;
    end
    vectors++;
    if (np != 25 || nn != 25 || nov != 0) begin
      errors++; $display("FAIL count_100 got pos=%0d neg=%0d overlap=%0d want 25 25 0", np, nn, nov);
    end
    en_a = 1'b0; @(negedge clk);
  endtask

  task automatic test_hp1();
    en_b = 1'b1;
    for (int p = 1; p <= 8; p++) begin
      @(negedge clk);
      vectors++;
      if ({sclk_b, pos_b, neg_b} !== {logic'(p % 2), logic'(p % 2), logic'(p % 2 == 0)}) begin
        errors++;
        $display("FAIL hp1 p=%0d got %b want %b", p, {sclk_b, pos_b, neg_b},
                 {logic'(p % 2), logic'(p % 2), logic'(p % 2 == 0)});
      end
    end
    en_b = 1'b0; @(negedge clk);
  endtask

  task automatic test_cpol1();
    en_c = 1'b1;
    for (int p = 1; p <= 9; p++) begin
      @(negedge clk);
      vectors++;
      if (p == 3 && {sclk_c, pos_c, neg_c} !== 3'b001) begin
        errors++; $display("FAIL cpol1_first got %b want 001", {sclk_c, pos_c, neg_c});
      end else if ({sclk_c, pos_c, neg_c} !== {exp_sclk(kc, 3, 1'b1), exp_pos(kc, 3, 1'b1), exp_neg(kc, 3, 1'b1)}) begin
        errors++; $display("FAIL cpol1 k=%0d got %b want %b", kc, {sclk_c, pos_c, neg_c},
                           {exp_sclk(kc, 3, 1'b1), exp_pos(kc, 3, 1'b1), exp_neg(kc, 3, 1'b1)});
      end
    end
    en_c = 1'b0; @(negedge clk);
  endtask

  task automatic test_en_drop();
    int n = 0;
    en_a = 1'b1;
    @(negedge clk);
    while (sclk_a !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (sclk_a !== 1'b1) begin
      errors++; $display("FAIL en_drop_wait got sclk=%b want 1 within 10 clk", sclk_a);
    end
    en_a = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sclk_a, pos_a, neg_a} !== 3'b000) begin
      errors++; $display("FAIL en_drop_idle got %b want 000", {sclk_a, pos_a, neg_a});
    end
    en_a = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (pos_a !== 1'b1 && n < 10);
    vectors++;
    if (n != 2 || sclk_a !== 1'b1) begin
      errors++; $display("FAIL en_reenable got first pos after %0d clk want 2", n);
    end
    en_a = 1'b0; @(negedge clk);
  endtask

  task automatic test_async_reset();
    en_a = 1'b1; en_c = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({sclk_a, pos_a, neg_a, sclk_c, pos_c, neg_c} !== 6'b000100) begin
      errors++; $display("FAIL async_reset got %b want 000100", {sclk_a, pos_a, neg_a, sclk_c, pos_c, neg_c});
    end
    en_c = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 1; p <= 8; p++) begin
      @(negedge clk);
      vectors++;
      if ({sclk_a, pos_a, neg_a} !== {logic'((p / 2) % 2), logic'(p % 4 == 2), logic'(p % 4 == 0)}) begin
        errors++; $display("FAIL restart p=%0d got %b", p, {sclk_a, pos_a, neg_a});
      end
    end
    en_a = 1'b0; @(negedge clk);
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      vectors++;
      if ({sclk_a, pos_a, neg_a} !== {exp_sclk(ka, 2, 1'b0), exp_pos(ka, 2, 1'b0), exp_neg(ka, 2, 1'b0)}) begin
        errors++; $display("FAIL rand_a i=%0d k=%0d got %b", i, ka, {sclk_a, pos_a, neg_a});
      end
      vectors++;
      if ({sclk_b, pos_b, neg_b} !== {exp_sclk(kb, 1, 1'b0), exp_pos(kb, 1, 1'b0), exp_neg(kb, 1, 1'b0)}) begin
        errors++; $display("FAIL rand_b i=%0d k=%0d got %b", i, kb, {sclk_b, pos_b, neg_b});
      end
      vectors++;
      if ({sclk_c, pos_c, neg_c} !== {exp_sclk(kc, 3, 1'b1), exp_pos(kc, 3, 1'b1), exp_neg(kc, 3, 1'b1)}) begin
        errors++; $display("FAIL rand_c i=%0d k=%0d got %b", i, kc, {sclk_c, pos_c, neg_c});
      end
      en_a = ($urandom_range(0, 7) != 0);
      en_b = ($urandom_range(0, 7) != 0);
      en_c = ($urandom_range(0, 7) != 0);
    end
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_consumer();
    test_basic_sequence();
    test_count_100();
    test_hp1();
    test_cpol1();
    test_en_drop();
    test_async_reset();
    test_random_en();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
